// File: rtl/rsff_bank.sv
// Bank of WIDTH independent set/reset flip-flops with parallel load, a conflict
// pulse, a sticky error flag, and a conflict counter enabled by RSFF_BANK_CONFLICT_CNT_EN.
module rsff_bank #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             load,
    input  logic [WIDTH-1:0] Qin,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Qout,
    output logic [WIDTH-1:0] Qoutbar,
    output logic             conflict,
    output logic             err_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [WIDTH-1:0] qState;
    logic [WIDTH-1:0] qNext;
    logic             anyConflict;

    assign anyConflict = |(S & R);

    // Unrecognised MODE values fall through to the default arm and hold.
    always_comb begin
        qNext = qState;
        for (int i = 0; i < WIDTH; i++) begin
            case ({S[i], R[i]})
                2'b00: qNext[i] = load ? Qin[i] : qState[i];
                2'b01: qNext[i] = 1'b0;
                2'b10: qNext[i] = 1'b1;
                default: begin
                    case (MODE)
                        1:       qNext[i] = 1'b1;
                        2:       qNext[i] = 1'b0;
                        3:       qNext[i] = ~qState[i];
                        default: qNext[i] = qState[i];
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qState <= '0;
        end else begin
            qState <= qNext;
        end
    end

    assign Qout    = qState;
    assign Qoutbar = ~qState;

    // A conflict in the same cycle as clr_err leaves the sticky flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            conflict <= anyConflict;
            if (anyConflict) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef RSFF_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cntState;

    // Clear takes priority over a simultaneous conflict; the count never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cntState <= '0;
        end else if (clr_err) begin
            cntState <= '0;
        end else if (anyConflict && (cntState != {CNT_W{1'b1}})) begin
            cntState <= cntState + 1'b1;
        end
    end

    assign conflict_cnt = cntState;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_rsff_bank.sv
// Randomised and directed bench for rsff_bank: five instances (MODE 0..3 and an
// out-of-range MODE) share stimulus and are compared against a bitwise reference model.
module tb_rsff_bank;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] S, R, Qin;
    logic       load, clr_err;

    logic [7:0] qOut [5];
    logic [7:0] qBar [5];
    logic       conf [5];
    logic       err  [5];
    logic [3:0] cnt  [5];

    logic [7:0] mQ [5];
    logic       mConf, mErr;
    int         mCnt;
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    for (genvar m = 0; m < 5; m++) begin : g_dut
        rsff_bank #(.WIDTH(8), .MODE(m == 4 ? 5 : m), .CNT_W(4)) dut (
            .clock(clock), .reset(reset), .S(S), .R(R), .load(load), .Qin(Qin),
            .clr_err(clr_err), .Qout(qOut[m]), .Qoutbar(qBar[m]), .conflict(conf[m]),
            .err_sticky(err[m]), .conflict_cnt(cnt[m])
        );
    end

    function automatic logic [3:0] expCnt();
`ifdef RSFF_BANK_CONFLICT_CNT_EN
        return mCnt[3:0];
`else
        return 4'd0;
`endif
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 5; m++) mQ[m] = 8'h00;
        mConf = 1'b0;
        mErr  = 1'b0;
        mCnt  = 0;
    endtask

    // Drives one cycle of inputs at the falling edge and advances the model at the rising edge.
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] r, input logic ld,
                                 input logic [7:0] qin, input logic clr);
        logic [7:0] both, idle, base;
        int pol;
        @(negedge clock);
        S = s; R = r; load = ld; Qin = qin; clr_err = clr;
        @(posedge clock);
        both = s & r;
        idle = ~s & ~r;
        for (int m = 0; m < 5; m++) begin
            pol  = (m == 4) ? 0 : m;
            base = (s & ~r) | (idle & (ld ? qin : mQ[m]));
            case (pol)
                1:       mQ[m] = base | both;
                2:       mQ[m] = base;
                3:       mQ[m] = base | (both & ~mQ[m]);
                default: mQ[m] = base | (both & mQ[m]);
            endcase
        end
        mConf = |both;
        if (clr)        mCnt = 0;
        else if (mConf) mCnt = (mCnt + 1 > 15) ? 15 : mCnt + 1;
        if (mConf)      mErr = 1'b1;
        else if (clr)   mErr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; S = 8'hFF; R = 8'h00; load = 1'b1; Qin = 8'hFF; clr_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        modelReset();
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== 8'h00) begin errors++; $display("[TB] FAIL reset_q m%0d got=%h exp=00", m, qOut[m]); end
            checks++; if (qBar[m] !== 8'hFF) begin errors++; $display("[TB] FAIL reset_qbar m%0d got=%h exp=ff", m, qBar[m]); end
            checks++; if (conf[m] !== 1'b0) begin errors++; $display("[TB] FAIL reset_conf m%0d got=%b exp=0", m, conf[m]); end
            checks++; if (err[m] !== 1'b0) begin errors++; $display("[TB] FAIL reset_err m%0d got=%b exp=0", m, err[m]); end
            checks++; if (cnt[m] !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt m%0d got=%0d exp=0", m, cnt[m]); end
        end
        @(negedge clock);
        reset = 1'b0; S = 8'h00; load = 1'b0; Qin = 8'h00;
    endtask

    task automatic test_set_reset_load();
        logic [7:0] pat [2] = '{8'h0F, 8'hA5};
        for (int k = 0; k < 2; k++) begin
            if (k == 0) applyStimulus(8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0);
            else        applyStimulus(8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
            for (int m = 0; m < 5; m++) begin
                checks++; if (qOut[m] !== pat[k]) begin errors++; $display("[TB] FAIL srload_q k%0d m%0d got=%h exp=%h", k, m, qOut[m], pat[k]); end
                checks++; if (qBar[m] !== ~pat[k]) begin errors++; $display("[TB] FAIL srload_qbar k%0d m%0d got=%h exp=%h", k, m, qBar[m], ~pat[k]); end
                checks++; if (conf[m] !== 1'b0) begin errors++; $display("[TB] FAIL srload_conf k%0d m%0d got=%b exp=0", k, m, conf[m]); end
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] expQ [5] = '{8'h55, 8'hFF, 8'h00, 8'hAA, 8'h55};
        applyStimulus(8'h55, 8'hAA, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'h33, 1'b0);
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== expQ[m]) begin errors++; $display("[TB] FAIL mode_q m%0d got=%h exp=%h", m, qOut[m], expQ[m]); end
            checks++; if (qOut[m] !== mQ[m]) begin errors++; $display("[TB] FAIL mode_model m%0d got=%h exp=%h", m, qOut[m], mQ[m]); end
            checks++; if (qBar[m] !== ~expQ[m]) begin errors++; $display("[TB] FAIL mode_qbar m%0d got=%h exp=%h", m, qBar[m], ~expQ[m]); end
            checks++; if (conf[m] !== 1'b1) begin errors++; $display("[TB] FAIL mode_conf m%0d got=%b exp=1", m, conf[m]); end
            checks++; if (err[m] !== 1'b1) begin errors++; $display("[TB] FAIL mode_err m%0d got=%b exp=1", m, err[m]); end
        end
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int m = 0; m < 5; m++) begin
            checks++; if (conf[m] !== 1'b0) begin errors++; $display("[TB] FAIL mode_pulse m%0d got=%b exp=0", m, conf[m]); end
            checks++; if (err[m] !== 1'b1) begin errors++; $display("[TB] FAIL mode_sticky m%0d got=%b exp=1", m, err[m]); end
        end
    endtask

    task automatic test_counter_saturation();
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
            for (int m = 0; m < 5; m++) begin
                checks++; if (cnt[m] !== expCnt()) begin errors++; $display("[TB] FAIL sat_cnt k%0d m%0d got=%0d exp=%0d", k, m, cnt[m], expCnt()); end
                checks++; if (conf[m] !== 1'b1) begin errors++; $display("[TB] FAIL sat_conf k%0d m%0d got=%b exp=1", k, m, conf[m]); end
            end
        end
        applyStimulus(8'h01, 8'h01, 1'b0, 8'h00, 1'b1);
        for (int m = 0; m < 5; m++) begin
            checks++; if (cnt[m] !== 4'd0) begin errors++; $display("[TB] FAIL clr_cnt m%0d got=%0d exp=0", m, cnt[m]); end
            checks++; if (err[m] !== 1'b1) begin errors++; $display("[TB] FAIL clr_err_kept m%0d got=%b exp=1", m, err[m]); end
            checks++; if (conf[m] !== 1'b1) begin errors++; $display("[TB] FAIL clr_conf m%0d got=%b exp=1", m, conf[m]); end
        end
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int m = 0; m < 5; m++) begin
            checks++; if (err[m] !== 1'b0) begin errors++; $display("[TB] FAIL clr_err_only m%0d got=%b exp=0", m, err[m]); end
            checks++; if (qOut[m] !== mQ[m]) begin errors++; $display("[TB] FAIL clr_q m%0d got=%h exp=%h", m, qOut[m], mQ[m]); end
        end
    endtask

    task automatic test_no_conflict();
        applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        applyStimulus(8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'h01, 8'h02, 1'b1, 8'hFC, 1'b0);
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== 8'hFD) begin errors++; $display("[TB] FAIL noconf_q m%0d got=%h exp=fd", m, qOut[m]); end
            checks++; if (conf[m] !== 1'b0) begin errors++; $display("[TB] FAIL noconf_conf m%0d got=%b exp=0", m, conf[m]); end
            checks++; if (cnt[m] !== expCnt()) begin errors++; $display("[TB] FAIL noconf_cnt m%0d got=%0d exp=%0d", m, cnt[m], expCnt()); end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== 8'h00) begin errors++; $display("[TB] FAIL async_q m%0d got=%h exp=00", m, qOut[m]); end
            checks++; if (qBar[m] !== 8'hFF) begin errors++; $display("[TB] FAIL async_qbar m%0d got=%h exp=ff", m, qBar[m]); end
            checks++; if (cnt[m] !== 4'd0) begin errors++; $display("[TB] FAIL async_cnt m%0d got=%0d exp=0", m, cnt[m]); end
            checks++; if (err[m] !== 1'b0) begin errors++; $display("[TB] FAIL async_err m%0d got=%b exp=0", m, err[m]); end
        end
        @(negedge clock);
        S = 8'hFF; R = 8'hFF; load = 1'b1; Qin = 8'h5A; clr_err = 1'b0;
        @(posedge clock);
        #1;
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== 8'h00) begin errors++; $display("[TB] FAIL held_q m%0d got=%h exp=00", m, qOut[m]); end
            checks++; if (conf[m] !== 1'b0) begin errors++; $display("[TB] FAIL held_conf m%0d got=%b exp=0", m, conf[m]); end
        end
        @(negedge clock);
        reset = 1'b0; S = 8'h00; R = 8'h00; load = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b1, 8'h3C, 1'b0);
        for (int m = 0; m < 5; m++) begin
            checks++; if (qOut[m] !== 8'h3C) begin errors++; $display("[TB] FAIL post_reset_q m%0d got=%h exp=3c", m, qOut[m]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] s, r, qin;
        for (int k = 0; k < 300; k++) begin
            s   = 8'($urandom);
            r   = 8'($urandom);
            qin = 8'($urandom);
            if ($urandom_range(0, 1) == 0) r = r & ~s;
            applyStimulus(s, r, 1'($urandom), qin, ($urandom_range(0, 15) == 0));
            for (int m = 0; m < 5; m++) begin
                checks++; if (qOut[m] !== mQ[m]) begin errors++; $display("[TB] FAIL rand_q k%0d m%0d got=%h exp=%h", k, m, qOut[m], mQ[m]); end
                checks++; if (qBar[m] !== ~mQ[m]) begin errors++; $display("[TB] FAIL rand_qbar k%0d m%0d got=%h exp=%h", k, m, qBar[m], ~mQ[m]); end
                checks++; if (conf[m] !== mConf) begin errors++; $display("[TB] FAIL rand_conf k%0d m%0d got=%b exp=%b", k, m, conf[m], mConf); end
                checks++; if (err[m] !== mErr) begin errors++; $display("[TB] FAIL rand_err k%0d m%0d got=%b exp=%b", k, m, err[m], mErr); end
                checks++; if (cnt[m] !== expCnt()) begin errors++; $display("[TB] FAIL rand_cnt k%0d m%0d got=%0d exp=%0d", k, m, cnt[m], expCnt()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_reset_load();
        test_modes();
        test_counter_saturation();
        test_no_conflict();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
